// File: rtl/exec_sequencer.sv
// ---------------------------------------------------------------------------
// exec_sequencer
//   Micro-sequencer that runs a 16-word program out of a small internal
//   program memory. It fetches each instruction word, decodes it, and either:
//     - handles control flow itself (HALT, JMP, JC), or
//     - hands an operation to an external datapath with a one-cycle strobe.
//   A watchdog ends any run that executes too many instructions.
//
// Parameters
//   MAX_STEPS     watchdog limit on instructions decoded per run
//
// Ports
//   i_clk         clock; all state changes on the rising edge
//   i_rst         asynchronous active-high reset
//   i_start       begin a run at address 0 (sampled only in IDLE)
//   i_abort       terminate a run in progress
//   i_pload_en    program-memory write strobe (honored only in IDLE)
//   i_pload_addr  program-memory write address
//   i_pload_data  instruction word: [7:4] opcode, [3:0] operand
//   i_carry       datapath carry/borrow status, consumed by JC
//   o_opr         opcode presented to the datapath
//   o_opa         operand presented to the datapath
//   o_exec_en     one-cycle execute strobe for the datapath
//   o_pc          current program counter
//   o_busy        high whenever the sequencer is not IDLE
//   o_done        one-cycle pulse on HALT completion
//   o_err         00 none, 01 illegal opcode, 10 watchdog; sticky until START
// ---------------------------------------------------------------------------
module exec_sequencer #(
  parameter int MAX_STEPS = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_pload_en,
  input  logic [3:0] i_pload_addr,
  input  logic [7:0] i_pload_data,
  input  logic       i_carry,
  output logic [3:0] o_opr,
  output logic [3:0] o_opa,
  output logic       o_exec_en,
  output logic [3:0] o_pc,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_err
);

  localparam int STEP_W = (MAX_STEPS < 2) ? 1 : $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_WDOG    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [0:15];
  logic [7:0]        r_ir;
  logic [3:0]        r_pc;
  logic [STEP_W-1:0] r_steps;
  logic              r_exec_en;
  logic              r_done;
  logic              r_busy;
  logic [1:0]        r_err;

  logic              w_mem_we;
  logic [3:0]        w_opr;
  logic [3:0]        w_opa;
  logic [STEP_W-1:0] w_step_next;
  logic              w_wdog_hit;

  // A START in the same cycle as a write wins and the write is dropped.
  assign w_mem_we    = (r_state == ST_IDLE) && i_pload_en && !i_start && !i_rst;
  assign w_opr       = r_ir[7:4];
  assign w_opa       = r_ir[3:0];
  assign w_step_next = r_steps + STEP_W'(1);
  assign w_wdog_hit  = (w_step_next == STEP_LIMIT);

  // Program memory write port; deliberately has no reset so a program
  // survives RST.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[i_pload_addr] <= i_pload_data;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ir      <= 8'h00;
      r_pc      <= 4'h0;
      r_steps   <= '0;
      r_exec_en <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= ERR_NONE;
    end else begin
      // Strobes are single-cycle unless a transition below raises them.
      r_exec_en <= 1'b0;
      r_done    <= 1'b0;
      if ((r_state != ST_IDLE) && i_abort) begin
        // ABORT beats every other transition and leaves ERR alone.
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_pc    <= 4'h0;
              r_steps <= '0;
              r_err   <= ERR_NONE;
              r_state <= ST_FETCH;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          ST_FETCH: begin
            r_ir    <= r_mem[r_pc];
            r_state <= ST_DECODE;
          end
          ST_DECODE: begin
            r_steps <= w_step_next;
            if (w_opr == OP_HALT) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_opr[3]) begin
              // Opcodes 8..F are not defined.
              r_err   <= ERR_ILLEGAL;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_wdog_hit) begin
              r_err   <= ERR_WDOG;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              case (w_opr)
                OP_JMP: begin
                  r_pc    <= w_opa;
                  r_state <= ST_FETCH;
                end
                OP_JC: begin
                  r_pc    <= i_carry ? w_opa : (r_pc + 4'd1);
                  r_state <= ST_FETCH;
                end
                default: begin
                  // Datapath ops 1..5: strobe is high for the EXEC cycle.
                  r_exec_en <= 1'b1;
                  r_state   <= ST_EXEC;
                end
              endcase
            end
          end
          ST_EXEC: begin
            r_state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            // Extra cycle lets CARRY settle before a following JC; PC wraps
            // naturally at 4 bits.
            r_pc    <= r_pc + 4'd1;
            r_state <= ST_FETCH;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_opr     = r_ir[7:4];
  assign o_opa     = r_ir[3:0];
  assign o_exec_en = r_exec_en;
  assign o_pc      = r_pc;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

// File: tb/tb_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_sequencer
//   Directed scoreboard bench for exec_sequencer. Stimulus pushes expected
//   events (EXEC strobes and end-of-run outcomes, with cycle offsets from
//   START acceptance) into a queue. A negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_exec_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_abort;
  logic       i_pload_en;
  logic [3:0] i_pload_addr;
  logic [7:0] i_pload_data;
  logic       i_carry;
  logic [3:0] o_opr;
  logic [3:0] o_opa;
  logic       o_exec_en;
  logic [3:0] o_pc;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_err;

  exec_sequencer #(.MAX_STEPS(255)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_pload_en(i_pload_en), .i_pload_addr(i_pload_addr),
    .i_pload_data(i_pload_data), .i_carry(i_carry),
    .o_opr(o_opr), .o_opa(o_opa), .o_exec_en(o_exec_en), .o_pc(o_pc),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  localparam int EV_EXEC = 0;
  localparam int EV_END  = 1;

  typedef struct {
    int kind;
    int opr;
    int opa;
    int done;
    int err;
    int pc;
    int rel;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  n_checks  = 0;
  int  n_errors  = 0;
  int  t_cyc     = 0;
  int  start_cyc = 0;
  bit  prev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exec(input int opr, input int opa, input int rel);
    ev_t e;
    e.kind = EV_EXEC; e.opr = opr; e.opa = opa;
    e.done = 0; e.err = 0; e.pc = 0; e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic push_end(input int done, input int err, input int pc, input int rel);
    ev_t e;
    e.kind = EV_END; e.opr = 0; e.opa = 0;
    e.done = done; e.err = err; e.pc = pc; e.rel = rel;
    exp_q.push_back(e);
  endtask

  // Cycle counter for latency measurement.
  always @(posedge i_clk) t_cyc <= t_cyc + 1;

  // Monitor: compares DUT events against the scoreboard queue.
  always @(negedge i_clk) begin
    if (o_busy && !prev_busy) begin
      start_cyc = t_cyc;
      chk("err_cleared_on_start", int'(o_err), 0);
    end
    if (o_exec_en) begin
      if (exp_q.size() == 0 || exp_q[0].kind != EV_EXEC) begin
        chk("exec_unexpected", 1, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("exec_opr", int'(o_opr), mon_ev.opr);
        chk("exec_opa", int'(o_opa), mon_ev.opa);
        chk("exec_cycle", t_cyc - start_cyc, mon_ev.rel);
      end
    end
    if (!o_busy && prev_busy) begin
      if (exp_q.size() == 0 || exp_q[0].kind != EV_END) begin
        chk("end_unexpected", 1, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("end_done", int'(o_done), mon_ev.done);
        chk("end_err", int'(o_err), mon_ev.err);
        chk("end_pc", int'(o_pc), mon_ev.pc);
        chk("end_cycle", t_cyc - start_cyc, mon_ev.rel);
      end
    end else if (o_done) begin
      chk("done_stray", 1, 0);
    end
    prev_busy = o_busy;
  end

  task automatic pload(input int addr, input int data);
    @(negedge i_clk);
    i_pload_en   = 1'b1;
    i_pload_addr = 4'(addr);
    i_pload_data = 8'(data);
    @(negedge i_clk);
    i_pload_en   = 1'b0;
  endtask

  task automatic start_run(input bit with_load);
    @(negedge i_clk);
    i_start = 1'b1;
    if (with_load) begin
      i_pload_en   = 1'b1;
      i_pload_addr = 4'h0;
      i_pload_data = 8'h9A;
    end
    @(negedge i_clk);
    i_start    = 1'b0;
    i_pload_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge i_clk);
    while (o_busy && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_reached_idle"}, int'(o_busy), 0);
    repeat (2) @(negedge i_clk);
  endtask

  task automatic load_basic();
    pload(0, 8'h1D); pload(1, 8'h20); pload(2, 8'h17);
    pload(3, 8'h40); pload(4, 8'h00);
  endtask

  task automatic expect_basic();
    push_exec(1, 13, 2); push_exec(2, 0, 6); push_exec(1, 7, 10);
    push_exec(4, 0, 14); push_end(1, 0, 4, 18);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_pc"}, int'(o_pc), 0);
    chk({tag, "_opr"}, int'(o_opr), 0);
    chk({tag, "_opa"}, int'(o_opa), 0);
    chk({tag, "_exec_en"}, int'(o_exec_en), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_err"}, int'(o_err), 0);
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_pload_en = 1'b0;
    i_pload_addr = 4'h0; i_pload_data = 8'h00; i_carry = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;

    // Four datapath ops then HALT.
    load_basic();
    expect_basic();
    start_run(1'b0);
    wait_idle(100, "basic");

    // JC taken with CARRY=1, then not taken with CARRY=0.
    pload(0, 8'h73); pload(1, 8'h00); pload(3, 8'h00);
    i_carry = 1'b1;
    push_end(1, 0, 3, 4);
    start_run(1'b0);
    wait_idle(50, "jc_taken");
    i_carry = 1'b0;
    push_end(1, 0, 1, 4);
    start_run(1'b0);
    wait_idle(50, "jc_not_taken");

    // Illegal opcode.
    pload(0, 8'h9A);
    push_end(0, 1, 0, 2);
    start_run(1'b0);
    wait_idle(50, "illegal");

    // Watchdog on a JMP-to-self loop: 255 decodes at 2 cycles each.
    pload(0, 8'h60);
    push_end(0, 2, 0, 510);
    start_run(1'b0);
    wait_idle(700, "watchdog");

    // PC wrap: JC to 14 (CARRY=1), ops at 14 and 15, wrap to 0,
    // JC falls through (CARRY=0) to HALT at 1.
    pload(0, 8'h7E); pload(1, 8'h00);
    for (int i = 2; i < 14; i++) pload(i, 8'h10 + i);
    pload(14, 8'h3A); pload(15, 8'h5C);
    i_carry = 1'b1;
    push_exec(3, 10, 4); push_exec(5, 12, 8); push_end(1, 0, 1, 14);
    start_run(1'b0);
    repeat (5) @(negedge i_clk);
    i_carry = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("pc_wrap", int'(o_pc), 0);
    wait_idle(50, "wrap");

    // ABORT during EXEC, with a memory write attempted while busy.
    load_basic();
    push_exec(1, 13, 2); push_end(0, 0, 0, 3);
    start_run(1'b0);
    i_pload_en = 1'b1; i_pload_addr = 4'h0; i_pload_data = 8'h9A;
    for (int n = 0; n < 20 && !o_exec_en; n++) @(negedge i_clk);
    chk("abort_reached_exec", int'(o_exec_en), 1);
    i_abort = 1'b1; i_pload_en = 1'b0;
    @(negedge i_clk);
    i_abort = 1'b0;
    wait_idle(50, "abort");

    // Rerun with START and PLOAD_EN together: program must be intact.
    expect_basic();
    start_run(1'b1);
    wait_idle(100, "rerun_start_load");

    // Asynchronous reset between edges mid-run.
    push_exec(1, 13, 2); push_exec(2, 0, 6); push_end(0, 0, 0, 7);
    start_run(1'b0);
    repeat (7) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // Memory survives reset.
    expect_basic();
    start_run(1'b0);
    wait_idle(100, "after_reset");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
